// File: rtl/ksa_pkg.sv
// ksa_pkg: shared constants and FSM state encodings for the byte-serial Kogge-Stone adder
package ksa_pkg;
  localparam int BYTE_W = 8;
  localparam int NBYTES_MIN = 1;
  localparam int NBYTES_MAX = 16;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;
endpackage

// File: rtl/ksa_top.sv
// ksa_top: 8-bit Kogge-Stone adder core with carry-in and carry-out
module ksa_top (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       c0,
  output logic [7:0] o_sum,
  output logic       o_cout
);
  logic [7:0] g, p;
  logic [8:0] c;
  always_comb begin
    g = i_a & i_b;
    p = i_a ^ i_b;
    for (int s = 0; s < 3; s++)
      for (int i = 7; i >= (1 << s); i--) begin
        g[i] = g[i] | (p[i] & g[i - (1 << s)]);
        p[i] = p[i] & p[i - (1 << s)];
      end
    c = {g | (p & {8{c0}}), c0};
  end
  assign o_sum  = i_a ^ i_b ^ c[7:0];
  assign o_cout = c[8];
endmodule

// File: rtl/ksa_seq.sv
// ksa_seq: byte-serial multi-precision add over one 8-bit Kogge-Stone core; KSA_SEQ_SUB_EN adds i_sub (subtract)
module ksa_seq
  import ksa_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [BYTE_W*NBYTES-1:0] i_a,
  input  logic [BYTE_W*NBYTES-1:0] i_b,
  input  logic                    i_cin,
`ifdef KSA_SEQ_SUB_EN
  input  logic                    i_sub,
`endif
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [BYTE_W*NBYTES-1:0] o_sum,
  output logic                    o_cout,
  output logic                    o_ovf
);
  localparam int W  = BYTE_W * NBYTES;
  localparam int CW = NBYTES > 1 ? $clog2(NBYTES) : 1;
  if (NBYTES < NBYTES_MIN || NBYTES > NBYTES_MAX) begin : g_bad_nbytes
    $error("ksa_seq: NBYTES out of range");
  end
  state_t state, state_nx;
  logic [W-1:0] a_q, b_q, sum_q;
  logic [CW-1:0] k;
  logic carry, cout_q, ovf_q, sub_q, sub_in, last, add_cout;
  logic [BYTE_W-1:0] a_byte, b_byte, add_sum;
`ifdef KSA_SEQ_SUB_EN
  assign sub_in = i_sub;
`else
  assign sub_in = 1'b0;
`endif
  assign a_byte = a_q[BYTE_W*k +: BYTE_W];
  assign b_byte = b_q[BYTE_W*k +: BYTE_W] ^ {BYTE_W{sub_q}};
  assign last   = k == CW'(NBYTES - 1);
  ksa_top u_add (
    .i_a   (a_byte),
    .i_b   (b_byte),
    .c0    (carry),
    .o_sum (add_sum),
    .o_cout(add_cout)
  );
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nx;
  end
  always_comb begin
    state_nx = state == IDLE ? (i_valid ? RUN  : IDLE) :
               state == RUN  ? (last    ? DONE : RUN)  :
               state == DONE ? (i_ready ? IDLE : DONE) : IDLE;
  end
  always_comb begin
    o_ready = state == IDLE;
    o_valid = state == DONE;
  end
  // subtract is a + ~b + 1, so the carry seed is forced to 1 and i_cin dropped
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      k      <= '0;
      carry  <= 1'b0;
      sub_q  <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (state == IDLE && i_valid) begin
      a_q   <= i_a;
      b_q   <= i_b;
      sub_q <= sub_in;
      carry <= sub_in | i_cin;
      k     <= '0;
    end else if (state == RUN) begin
      sum_q[BYTE_W*k +: BYTE_W] <= add_sum;
      carry <= add_cout;
      if (last) begin
        cout_q <= add_cout;
        ovf_q  <= (a_byte[BYTE_W-1] == b_byte[BYTE_W-1]) & (add_sum[BYTE_W-1] != a_byte[BYTE_W-1]);
      end else begin
        k <= k + 1'b1;
      end
    end
  end
  assign o_sum  = sum_q;
  assign o_cout = cout_q;
  assign o_ovf  = ovf_q;
endmodule

// File: tb/tb_ksa_seq.sv
// tb_ksa_seq: directed self-checking bench for ksa_seq against an arithmetic reference model
module tb_ksa_seq;
  localparam int NB = 4;
  localparam int W  = 8 * NB;
  typedef logic [W+1:0] v_t;
  logic clk = 1'b0, rst_n = 1'b0, valid = 1'b0, ready_in = 1'b0, cin = 1'b0, sub = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic o_ready, o_valid, o_cout, o_ovf;
  logic [W-1:0] o_sum;
  int n_cmp = 0, n_bad = 0;
  v_t q[$];
  always #5 clk = ~clk;
  ksa_seq #(.NBYTES(NB)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_valid(valid),
    .o_ready(o_ready),
    .i_a    (a),
    .i_b    (b),
    .i_cin  (cin),
`ifdef KSA_SEQ_SUB_EN
    .i_sub  (sub),
`endif
    .o_valid(o_valid),
    .i_ready(ready_in),
    .o_sum  (o_sum),
    .o_cout (o_cout),
    .o_ovf  (o_ovf)
  );
  function automatic v_t model(logic [W-1:0] x, logic [W-1:0] y, logic c, logic s);
    logic [W-1:0] yy;
    logic [W:0] f;
    yy = s ? ~y : y;
    f = {1'b0, x} + {1'b0, yy} + (W+1)'(s | c);
    return {f[W], (x[W-1] == yy[W-1]) && (f[W-1] != x[W-1]), f[W-1:0]};
  endfunction
  task automatic chk(string nm, v_t act, v_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (!rst_n) q.delete();
    else begin
      chk("ready_valid_exclusive", v_t'(o_ready & o_valid), v_t'(0));
      if (o_valid) begin
        if (q.size() == 0) chk("valid_without_request", v_t'(1), v_t'(0));
        else chk("model_result", {o_cout, o_ovf, o_sum}, q[0]);
      end
      if (o_valid && ready_in && q.size() > 0) void'(q.pop_front());
      if (valid && o_ready) q.push_back(model(a, b, cin, sub));
    end
  end
  task automatic send(logic [W-1:0] x, logic [W-1:0] y, logic c, logic s);
    chk("ready_before_accept", v_t'(o_ready), v_t'(1));
    a = x; b = y; cin = c; sub = s; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask
  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!o_valid && lat < 20);
    if (!o_valid) chk("valid_timeout", v_t'(0), v_t'(1));
  endtask
  task automatic release_result();
    ready_in = 1'b1;
    @(posedge clk); #1;
    ready_in = 1'b0;
    chk("valid_after_handshake", v_t'(o_valid), v_t'(0));
    chk("ready_after_handshake", v_t'(o_ready), v_t'(1));
  endtask
  task automatic op(string nm, logic [W-1:0] x, logic [W-1:0] y, logic c, logic s,
                    logic [W-1:0] es, logic ec, logic eo);
    int lat;
    send(x, y, c, s);
    wait_valid(lat);
    chk({nm, "_latency"}, v_t'(lat), v_t'(NB));
    chk({nm, "_sum"}, v_t'(o_sum), v_t'(es));
    chk({nm, "_cout"}, v_t'(o_cout), v_t'(ec));
    chk({nm, "_ovf"}, v_t'(o_ovf), v_t'(eo));
    release_result();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int lat;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", v_t'(o_ready), v_t'(1));
    chk("reset_valid", v_t'(o_valid), v_t'(0));
    chk("reset_sum", v_t'(o_sum), v_t'(0));
    chk("reset_cout", v_t'(o_cout), v_t'(0));
    chk("reset_ovf", v_t'(o_ovf), v_t'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    op("byte_carry", 32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0);
    op("full_wrap", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
    op("signed_ovf", 32'h7FFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h80000000, 1'b0, 1'b1);
    send(32'h12345678, 32'h11111111, 1'b0, 1'b0);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", v_t'(o_valid), v_t'(1));
      chk("hold_sum", v_t'(o_sum), v_t'(32'h23456789));
      @(posedge clk); #1;
    end
    release_result();
    send(32'h01010101, 32'h02020202, 1'b0, 1'b0);
    @(posedge clk); #1;
    a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    wait_valid(lat);
    chk("pulse_latency", v_t'(lat), v_t'(NB - 2));
    chk("pulse_sum", v_t'(o_sum), v_t'(32'h03030303));
    release_result();
    @(posedge clk); #1;
    chk("pulse_no_phantom", v_t'(o_valid), v_t'(0));
    send(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0);
    wait_valid(lat);
    chk("b2b_first_sum", v_t'(o_sum), v_t'(32'h00010000));
    a = 32'h80000000; b = 32'h80000000; cin = 1'b0; valid = 1'b1; ready_in = 1'b1;
    chk("b2b_ready_low", v_t'(o_ready), v_t'(0));
    @(posedge clk); #1;
    ready_in = 1'b0;
    chk("b2b_ready_high", v_t'(o_ready), v_t'(1));
    chk("b2b_valid_low", v_t'(o_valid), v_t'(0));
    @(posedge clk); #1;
    valid = 1'b0;
    wait_valid(lat);
    chk("b2b_latency", v_t'(lat), v_t'(NB));
    chk("b2b_sum", v_t'(o_sum), v_t'(32'h00000000));
    chk("b2b_cout", v_t'(o_cout), v_t'(1));
    chk("b2b_ovf", v_t'(o_ovf), v_t'(1));
    release_result();
    send(32'h11111111, 32'h22222222, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_ready", v_t'(o_ready), v_t'(1));
    chk("midrun_rst_valid", v_t'(o_valid), v_t'(0));
    chk("midrun_rst_sum", v_t'(o_sum), v_t'(0));
    chk("midrun_rst_cout", v_t'(o_cout), v_t'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", v_t'(o_valid), v_t'(0));
    op("after_reset", 32'h0F0F0F0F, 32'h01010101, 1'b1, 1'b0, 32'h10101011, 1'b0, 1'b0);
`ifdef KSA_SEQ_SUB_EN
    op("sub", 32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    op("sub_cin_ignored", 32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    op("sub_no_borrow", 32'h00000009, 32'h00000002, 1'b0, 1'b1, 32'h00000007, 1'b1, 1'b0);
`endif
    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
